// File: rtl/seq_pkg.sv
// Shared types and constants for the A/B accumulator CPU sequencer.
// Holds the FSM state enum, special opcodes and the IMEM word width.
package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  localparam int IMEM_W = 15;

  localparam logic [6:0] HALT_OPC = 7'b1111111;
  localparam logic [6:0] NOP_OPC  = 7'b1111110;

  localparam logic [6:0] JMP_OPC  = 7'b1010000;
  localparam logic [6:0] JEQ_OPC  = 7'b1010001;
  localparam logic [6:0] JNE_OPC  = 7'b1010010;
  localparam logic [6:0] JGT_OPC  = 7'b1010011;
  localparam logic [6:0] JLT_OPC  = 7'b1010100;
  localparam logic [6:0] JGE_OPC  = 7'b1010101;
  localparam logic [6:0] JLE_OPC  = 7'b1010110;
  localparam logic [6:0] JCR_OPC  = 7'b1010111;
  localparam logic [6:0] JOV_OPC  = 7'b1011000;

endpackage

// File: rtl/instr_sequencer_branch_eval.sv
// branch_eval: combinational jump decision from opcode and flags.
// Ports: opcode[6:0], flags_status[3:0] = {Z,N,C,V} in; taken out.
module branch_eval
  import seq_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [3:0] flags_status,
  output logic       taken
);

  logic z, n, c, v;

  assign z = flags_status[3];
  assign n = flags_status[2];
  assign c = flags_status[1];
  assign v = flags_status[0];

  always_comb begin
    taken = 1'b0;
    case (opcode)
      JMP_OPC: taken = 1'b1;
      JEQ_OPC: taken = z;
      JNE_OPC: taken = !z;
      JGT_OPC: taken = !n && !z;
      JLT_OPC: taken = n;
      JGE_OPC: taken = !n;
      JLE_OPC: taken = n || z;
      JCR_OPC: taken = c;
      JOV_OPC: taken = v;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: fetches into IR over req/ack, strobes one
// EXEC cycle, updates pc (incl. flag jumps when SEQ_JUMP_EN defined).
// Ports: clk, rst, run, imem_req/addr/ack/data, flags_status,
// opcode, k8, exec_en, pc, halted.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [IMEM_W-1:0] imem_data,
  input  logic [3:0]        flags_status,
  output logic [6:0]        opcode,
  output logic [7:0]        k8,
  output logic              exec_en,
  output logic [PC_W-1:0]   pc,
  output logic              halted
);

  state_t            state;
  state_t            state_next;
  logic [PC_W-1:0]   pc_next;
  logic [IMEM_W-1:0] ir;
  logic [IMEM_W-1:0] ir_next;
  logic              taken;

`ifdef SEQ_JUMP_EN
  branch_eval u_branch_eval (
    .opcode       (ir[14:8]),
    .flags_status (flags_status),
    .taken        (taken)
  );
`else
  logic unused_flags;
  assign unused_flags = ^flags_status;
  assign taken = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    case (state)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_next    = imem_data;
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ir[14:8] == HALT_OPC) begin
          state_next = S_HALT;
        end else begin
          state_next = S_FETCH;
          if (taken) pc_next = PC_W'(ir[7:0]);
          else       pc_next = pc + 1'b1;
        end
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outside EXEC the control unit sees NOP so no register loads occur.
  always_comb begin
    imem_req = 1'b0;
    exec_en  = 1'b0;
    halted   = 1'b0;
    opcode   = NOP_OPC;
    case (state)
      S_FETCH: imem_req = 1'b1;
      S_EXEC: begin
        exec_en = 1'b1;
        opcode  = ir[14:8];
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc;
  assign k8        = ir[7:0];

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer.
// Jump expectations follow SEQ_JUMP_EN as the RTL build does.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [14:0] imem_data = '0;
  logic [3:0]  flags_status = '0;
  logic [6:0]  opcode;
  logic [7:0]  k8;
  logic        exec_en;
  logic [7:0]  pc;
  logic        halted;

  int passed = 0;
  int total  = 0;

  localparam logic [14:0] ADD_AB = {7'h10, 8'h00};

  instr_sequencer #(.PC_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .flags_status (flags_status),
    .opcode       (opcode),
    .k8           (k8),
    .exec_en      (exec_en),
    .pc           (pc),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    run      = 1'b0;
    imem_ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic start();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic fetch_exec(input logic [14:0] d);
    check("fe_req", imem_req, 1);
    imem_ack  = 1'b1;
    imem_data = d;
    tick();
    imem_ack = 1'b0;
    check("fe_exec", exec_en, 1);
    check("fe_opc", opcode, d[14:8]);
    check("fe_k8", k8, d[7:0]);
    tick();
  endtask

  initial begin
    // reset state
    #2;
    check("rst_req", imem_req, 0);
    check("rst_exec", exec_en, 0);
    check("rst_opc", opcode, 7'h7E);
    check("rst_k8", k8, 0);
    check("rst_halt", halted, 0);
    check("rst_pc", pc, 0);

    // MOV A,0x05 then HALT
    do_reset();
    check("idle_req", imem_req, 0);
    start();
    check("f0_req", imem_req, 1);
    check("f0_addr", imem_addr, 0);
    check("f0_opc", opcode, 7'h7E);
    imem_ack  = 1'b1;
    imem_data = {7'h02, 8'h05};
    tick();
    imem_ack = 1'b0;
    check("e0_exec", exec_en, 1);
    check("e0_opc", opcode, 7'h02);
    check("e0_k8", k8, 8'h05);
    check("e0_pc", pc, 0);
    tick();
    check("f1_pc", pc, 1);
    check("f1_exec", exec_en, 0);
    check("f1_k8hold", k8, 8'h05);
    imem_ack  = 1'b1;
    imem_data = {7'h7F, 8'h00};
    tick();
    imem_ack = 1'b0;
    check("eh_opc", opcode, 7'h7F);
    check("eh_exec", exec_en, 1);
    tick();
    check("h_halted", halted, 1);
    check("h_pc", pc, 1);
    check("h_exec", exec_en, 0);
    check("h_opc", opcode, 7'h7E);
    check("h_req", imem_req, 0);
    run = 1'b1;
    tick();
    run = 1'b0;
    check("h2_halted", halted, 1);
    check("h2_pc", pc, 1);

    // ack delayed 3 cycles
    do_reset();
    start();
    for (int i = 0; i < 4; i++) begin
      check("w_req", imem_req, 1);
      check("w_addr", imem_addr, 0);
      check("w_opc", opcode, 7'h7E);
      check("w_exec", exec_en, 0);
      if (i == 3) begin
        imem_ack  = 1'b1;
        imem_data = {7'h02, 8'h11};
      end
      tick();
    end
    imem_ack = 1'b0;
    check("w_e_exec", exec_en, 1);
    check("w_e_k8", k8, 8'h11);
    tick();
    check("w_pc", pc, 1);

`ifdef SEQ_JUMP_EN
    fetch_exec(ADD_AB);
    fetch_exec(ADD_AB);
    check("j_pc3", imem_addr, 3);
    flags_status = 4'b1000;
    fetch_exec({7'b1010001, 8'h10});
    check("jeq_z1", imem_addr, 8'h10);
    flags_status = 4'b0000;
    fetch_exec({7'b1010000, 8'h03});
    check("jmp_back", imem_addr, 8'h03);
    fetch_exec({7'b1010001, 8'h10});
    check("jeq_z0", imem_addr, 8'h04);
    fetch_exec({7'b1010011, 8'h20});
    check("jgt", imem_addr, 8'h20);
    flags_status = 4'b0100;
    fetch_exec({7'b1010011, 8'h30});
    check("jgt_n", imem_addr, 8'h21);
    fetch_exec({7'b1010000, 8'h21});
    check("jmp_self", imem_addr, 8'h21);
`endif

    // JMP 0x40 at pc 5
    do_reset();
    start();
    for (int i = 0; i < 5; i++) fetch_exec(ADD_AB);
    check("p5_addr", imem_addr, 5);
    flags_status = 4'b0000;
    fetch_exec({7'b1010000, 8'h40});
`ifdef SEQ_JUMP_EN
    check("jmp40", imem_addr, 8'h40);
`else
    check("jmp40_nj", imem_addr, 8'h06);
`endif

    // async reset during a pending fetch
    tick();
    check("ar_req_pre", imem_req, 1);
    rst = 1'b1;
    #1;
    check("ar_req", imem_req, 0);
    check("ar_pc", pc, 0);
    check("ar_opc", opcode, 7'h7E);
    check("ar_k8", k8, 0);
    tick();
    rst       = 1'b0;
    imem_ack  = 1'b1;
    imem_data = {7'h02, 8'h77};
    tick();
    imem_ack = 1'b0;
    check("late_req", imem_req, 0);
    check("late_exec", exec_en, 0);
    check("late_k8", k8, 0);
    tick();
    check("idle_stay", imem_req, 0);
    check("idle_pc", pc, 0);

    // pc wrap 0xFF -> 0x00
    do_reset();
    start();
    for (int i = 0; i < 255; i++) fetch_exec(ADD_AB);
    check("wr_ff", imem_addr, 8'hFF);
    fetch_exec(ADD_AB);
    check("wr_00", imem_addr, 8'h00);
    check("wr_req", imem_req, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction fetch/execute sequencer for the A/B accumulator CPU. It fetches 15-bit instructions from instruction memory over a req/ack handshake and holds them in an instruction register. It presents the opcode and 8-bit literal to the combinational control unit and literal mux for exactly one execute cycle. It also maintains the program counter, including flag-conditioned jumps and HALT.

## Interface
- PC_W, 8: program counter / instruction address width (≥8)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  start request, sampled only in IDLE
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  PC_W  fetch address (= pc while imem_req)
- imem_ack  in  1  fetch complete; imem_data valid same cycle
- imem_data  in  15  {opcode[14:8], literal[7:0]}
- flags_status  in  4  {Z,N,C,V} from status register
- opcode  out  7  to control unit; IR opcode in EXEC, else NOP_OPC
- k8  out  8  literal to mux B; IR literal (held)
- exec_en  out  1  one-cycle execute strobe (status register load enable)
- pc  out  PC_W  current program counter
- halted  out  1  high in HALT state

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: run=1 → FETCH.
- FETCH: imem_req=1, imem_addr=pc; on imem_ack, capture imem_data into IR → EXEC.
- EXEC: exec_en=1, opcode=IR[14:8], k8=IR[7:0] for one cycle.
  - HALT_OPC (7'b1111111): pc unchanged → HALT.
  - Taken jump: pc ← {zero-extend} k8 → FETCH.
  - Otherwise: pc ← pc+1 mod 2^PC_W → FETCH.
- HALT: halted=1; exit only by reset.
- Jump opcodes and conditions, evaluated on flags_status during EXEC:
  - JMP 7'b1010000: always
  - JEQ 7'b1010001: Z
  - JNE 7'b1010010: !Z
  - JGT 7'b1010011: !N&!Z
  - JLT 7'b1010100: N
  - JGE 7'b1010101: !N
  - JLE 7'b1010110: N|Z
  - JCR 7'b1010111: C
  - JOV 7'b1011000: V
- Jump opcodes reach the control unit unchanged; it decodes them to no register load.
- Outside EXEC, opcode=NOP_OPC (7'b1111110), so the control unit outputs LA=LB=0. No external gating needed.

## Timing
- Reset values: state IDLE, pc 0, IR 0, imem_req 0, exec_en 0, opcode NOP_OPC, k8 0, halted 0.
- Instruction latency: minimum 2 cycles (FETCH with same-cycle ack, then EXEC); each ack wait cycle adds 1.
- imem_addr is stable and imem_req stays high from FETCH entry until the ack cycle inclusive.
- imem_ack outside FETCH is ignored.
- pc updates on the clock edge ending EXEC; next FETCH uses the new pc.
- flags_status reflects the previous instruction; flags updated by the current EXEC are not visible to itself.
- pc wrap: 2^PC_W−1 → 0.
- Jump to own address is legal (tight loop).
- Reset mid-operation: all outputs go to reset values immediately (async); an in-flight fetch is abandoned, and a late ack after reset is ignored in IDLE.
- run deassertion after leaving IDLE has no effect.

## Configuration
- SEQ_JUMP_EN defined: jump decode and flag evaluation as above.
- SEQ_JUMP_EN undefined: no branch logic; all jump opcodes execute as pc+1. flags_status is unused, but the port remains.

## Structure
- Shared package seq_pkg holds:
  - state enum
  - HALT_OPC, NOP_OPC and the jump opcode constants
  - IMEM_W=15
- One sub-module, branch_eval: combinational (opcode, flags_status) → taken. Instantiated only under SEQ_JUMP_EN.

## Test plan
- Reset, run=1, ack same cycle; program {MOV A,Lit 0x05; HALT} → exec_en with opcode 0x02, k8 0x05, pc 0→1; then HALT with halted=1, pc stays 1.
- Ack delayed 3 cycles → imem_req high and imem_addr constant for 4 cycles; opcode=NOP_OPC and exec_en=0 throughout.
- JEQ 0x10 at pc 3: with Z=1 → next fetch addr 0x10; with Z=0 → addr 0x04. JGT 0x20 with N=0, Z=0 → 0x20.
- pc=0xFF executing ADD A,B → next fetch addr 0x00.
- rst asserted the cycle after imem_req rises → imem_req=0 and pc=0 without a clock edge; ack next cycle ignored, state IDLE.
- SEQ_JUMP_EN undefined: JMP 0x40 at pc 5 → exec_en pulses, next addr 0x06.
